// File: rtl/cc_fill_deserializer_if.sv
// Bundle of the refill deserializer's external signals: miss-descriptor push
// side, snooped AXI R channel, line-write output and status.
//   master : environment side (miss handler, memory R channel, cache array)
//   slave  : the deserializer itself
interface cc_fill_deserializer_if #(
  parameter int ADDR_W = 26
);
  logic                miss_wren_i;
  logic [ADDR_W+2:0]   miss_wdata_i;
  logic                miss_fifo_afull_o;
  logic                miss_fifo_empty_o;
  logic [63:0]         mem_rdata_i;
  logic                mem_rlast_i;
  logic                mem_rvalid_i;
  logic                mem_rready_i;
  logic                fill_wren_o;
  logic [ADDR_W-1:0]   fill_addr_o;
  logic [511:0]        fill_wdata_o;
  logic                busy_o;
  logic                err_o;

  modport master (
    output miss_wren_i, miss_wdata_i,
    output mem_rdata_i, mem_rlast_i, mem_rvalid_i, mem_rready_i,
    input  miss_fifo_afull_o, miss_fifo_empty_o,
    input  fill_wren_o, fill_addr_o, fill_wdata_o,
    input  busy_o, err_o
  );

  modport slave (
    input  miss_wren_i, miss_wdata_i,
    input  mem_rdata_i, mem_rlast_i, mem_rvalid_i, mem_rready_i,
    output miss_fifo_afull_o, miss_fifo_empty_o,
    output fill_wren_o, fill_addr_o, fill_wdata_o,
    output busy_o, err_o
  );
endinterface

// File: rtl/cc_fill_deserializer.sv
// Cache-miss refill deserializer. Snoops the memory R channel, reassembles an
// 8-beat critical-word-first wrap burst into a 512-bit line in natural word
// order and issues one single-cycle line write to the cache array.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : cc_fill_deserializer_if.slave
//          miss_wren_i/miss_wdata_i   push {line_addr, word_offset}
//          miss_fifo_afull_o/empty_o  descriptor FIFO status
//          mem_r*_i                   snooped R channel (never back-pressured)
//          fill_wren_o/addr_o/wdata_o line write (1-cycle strobe, held data)
//          busy_o                     collecting a burst
//          err_o                      sticky protocol error
//
// state   | meaning
// IDLE    | waiting for the first (critical) beat of a burst
// COLLECT | beats 1..7 of the current burst being assembled
module cc_fill_deserializer #(
  parameter int ADDR_W          = 26,
  parameter int MISS_FIFO_DEPTH = 4,
  parameter int AFULL_LEVEL     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  cc_fill_deserializer_if.slave  bus
);

  localparam int PTR_W = $clog2(MISS_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  // Miss-descriptor FIFO
  logic [ADDR_W+2:0] fifo_mem [MISS_FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_empty, fifo_full;
  logic              push_ok, push_drop, pop;
  logic [ADDR_W-1:0] head_addr;
  logic [2:0]        head_off;

  // Assembly and control
  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        off_q, off_d;
  logic [7:0][63:0]  asm_q, asm_d;
  logic [2:0]        wr_idx;
  logic              beat, complete, proto_err;

  // Output register, independent of the assembly buffer
  logic              fill_wren_q;
  logic [ADDR_W-1:0] fill_addr_q;
  logic [7:0][63:0]  fill_data_q;
  logic              err_q;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNT_W'(MISS_FIFO_DEPTH));
  // A push into a full FIFO is dropped even if a pop happens that cycle.
  assign push_ok    = bus.miss_wren_i & ~fifo_full;
  assign push_drop  = bus.miss_wren_i & fifo_full;
  assign head_addr  = fifo_mem[rd_ptr][ADDR_W+2:3];
  assign head_off   = fifo_mem[rd_ptr][2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= bus.miss_wdata_i;
  end

  assign beat = bus.mem_rvalid_i & bus.mem_rready_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    off_d     = off_q;
    asm_d     = asm_q;
    pop       = 1'b0;
    complete  = 1'b0;
    proto_err = 1'b0;
    wr_idx    = off_q + cnt_q;   // 3-bit wrap gives the critical-word-first order
    case (state_q)
      IDLE: begin
        if (beat) begin
          if (!fifo_empty) begin
            pop           = 1'b1;
            addr_d        = head_addr;
            off_d         = head_off;
            asm_d[head_off] = bus.mem_rdata_i;
            if (bus.mem_rlast_i) begin
              proto_err = 1'b1;
            end else begin
              state_d = COLLECT;
              cnt_d   = 3'd1;
            end
          end else begin
            proto_err = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (beat) begin
          asm_d[wr_idx] = bus.mem_rdata_i;
          if (cnt_q == 3'd7) begin
            // Eight beats always close the line; a missing rlast is flagged
            // but the data is still written.
            complete = 1'b1;
            state_d  = IDLE;
            cnt_d    = 3'd0;
            if (!bus.mem_rlast_i) proto_err = 1'b1;
          end else if (bus.mem_rlast_i) begin
            proto_err = 1'b1;
            state_d   = IDLE;
            cnt_d     = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      addr_q      <= '0;
      off_q       <= 3'd0;
      asm_q       <= '0;
      fill_wren_q <= 1'b0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      off_q       <= off_d;
      asm_q       <= asm_d;
      fill_wren_q <= complete;
      if (complete) begin
        fill_addr_q <= addr_q;
        fill_data_q <= asm_d;   // includes the completing beat
      end
      err_q <= err_q | proto_err | push_drop;
    end
  end

  assign bus.miss_fifo_empty_o = fifo_empty;
  assign bus.miss_fifo_afull_o = (fifo_cnt >= CNT_W'(AFULL_LEVEL));
  assign bus.fill_wren_o       = fill_wren_q;
  assign bus.fill_addr_o       = fill_addr_q;
  assign bus.fill_wdata_o      = fill_data_q;
  assign bus.busy_o            = (state_q == COLLECT);
  assign bus.err_o             = err_q;

endmodule

// File: tb/tb_cc_fill_deserializer.sv
module tb_cc_fill_deserializer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  cc_fill_deserializer_if #(.ADDR_W(26)) bus_if ();

  cc_fill_deserializer #(
    .ADDR_W(26), .MISS_FIFO_DEPTH(4), .AFULL_LEVEL(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus_if.miss_wren_i  = 1'b0;
    bus_if.miss_wdata_i = '0;
    bus_if.mem_rdata_i  = '0;
    bus_if.mem_rlast_i  = 1'b0;
    bus_if.mem_rvalid_i = 1'b0;
    bus_if.mem_rready_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [25:0] addr, input logic [2:0] off);
    bus_if.miss_wren_i  = 1'b1;
    bus_if.miss_wdata_i = {addr, off};
    tick();
    bus_if.miss_wren_i  = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d, input logic last);
    bus_if.mem_rvalid_i = 1'b1;
    bus_if.mem_rready_i = 1'b1;
    bus_if.mem_rdata_i  = d;
    bus_if.mem_rlast_i  = last;
    tick();
    bus_if.mem_rvalid_i = 1'b0;
    bus_if.mem_rlast_i  = 1'b0;
  endtask

  task automatic burst(input logic [63:0] base);
    for (int k = 0; k < 8; k++) beat(base + 64'(k), k == 7);
  endtask

  // Beat k of a burst with critical word `off` lands in word (off+k) mod 8.
  function automatic logic [511:0] exp_line(input logic [2:0] off, input logic [63:0] base);
    logic [511:0] l;
    logic [2:0]   w;
    l = '0;
    for (int k = 0; k < 8; k++) begin
      w = off + 3'(k);
      l[64*w +: 64] = base + 64'(k);
    end
    return l;
  endfunction

  localparam logic [63:0] BASE1 = 64'hA5A5_0000_0000_0000;
  localparam logic [63:0] BASE2 = 64'hC0DE_0000_0000_00D0;
  localparam logic [63:0] BASEA = 64'h1000_0000_0000_0A00;
  localparam logic [63:0] BASEB = 64'h2000_0000_0000_0B00;
  localparam logic [63:0] BASEE = 64'h3000_0000_0000_0E00;
  localparam logic [63:0] BASEG = 64'h4000_0000_0000_0600;

  int pulses;
  int pulse_at [2];
  int nb;

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    rst = 1'b1;
    tick();
    check_val("rst_wren",  bus_if.fill_wren_o, 0);
    check_val("rst_addr",  bus_if.fill_addr_o, 0);
    check_val("rst_wdata", bus_if.fill_wdata_o, 0);
    check_val("rst_busy",  bus_if.busy_o, 0);
    check_val("rst_err",   bus_if.err_o, 0);
    check_val("rst_empty", bus_if.miss_fifo_empty_o, 1);
    check_val("rst_afull", bus_if.miss_fifo_afull_o, 0);
    tick();
    rst = 1'b0;

    // Offset 0
    push(26'h0000123, 3'd0);
    check_val("o0_empty", bus_if.miss_fifo_empty_o, 0);
    beat(BASE1, 1'b0);
    check_val("o0_busy", bus_if.busy_o, 1);
    for (int k = 1; k < 8; k++) beat(BASE1 + 64'(k), k == 7);
    check_val("o0_wren",  bus_if.fill_wren_o, 1);
    check_val("o0_addr",  bus_if.fill_addr_o, 26'h0000123);
    check_val("o0_word0", bus_if.fill_wdata_o[63:0], 64'hA5A5_0000_0000_0000);
    check_val("o0_word7", bus_if.fill_wdata_o[511:448], 64'hA5A5_0000_0000_0007);
    check_val("o0_line",  bus_if.fill_wdata_o, exp_line(3'd0, BASE1));
    check_val("o0_err",   bus_if.err_o, 0);
    check_val("o0_busy2", bus_if.busy_o, 0);
    tick();
    check_val("o0_wren_off", bus_if.fill_wren_o, 0);
    check_val("o0_hold",     bus_if.fill_wdata_o, exp_line(3'd0, BASE1));

    // Wrap order, offset 5
    push(26'h0ABCDE, 3'd5);
    burst(BASE2);
    check_val("wr_wren",  bus_if.fill_wren_o, 1);
    check_val("wr_addr",  bus_if.fill_addr_o, 26'h0ABCDE);
    check_val("wr_word0", bus_if.fill_wdata_o[63:0], 64'hC0DE_0000_0000_00D3);
    check_val("wr_word5", bus_if.fill_wdata_o[383:320], 64'hC0DE_0000_0000_00D0);
    check_val("wr_line",  bus_if.fill_wdata_o, exp_line(3'd5, BASE2));

    // Back-to-back bursts, afull at occupancy 2
    push(26'h00000AA, 3'd2);
    check_val("afull_1", bus_if.miss_fifo_afull_o, 0);
    push(26'h00000BB, 3'd7);
    check_val("afull_2", bus_if.miss_fifo_afull_o, 1);
    pulses = 0;
    bus_if.mem_rready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus_if.mem_rvalid_i = 1'b1;
      bus_if.mem_rdata_i  = (i < 8) ? BASEA + 64'(i) : BASEB + 64'(i - 8);
      bus_if.mem_rlast_i  = (i % 8) == 7;
      tick();
      if (bus_if.fill_wren_o) begin
        if (pulses < 2) pulse_at[pulses] = i;
        pulses++;
      end
      if (i == 7) begin
        check_val("b2b_addr_a", bus_if.fill_addr_o, 26'h00000AA);
        check_val("b2b_line_a", bus_if.fill_wdata_o, exp_line(3'd2, BASEA));
      end
      if (i == 8) check_val("b2b_busy_zero_bubble", bus_if.busy_o, 1);
      if (i == 15) begin
        check_val("b2b_addr_b", bus_if.fill_addr_o, 26'h00000BB);
        check_val("b2b_line_b", bus_if.fill_wdata_o, exp_line(3'd7, BASEB));
      end
    end
    idle_inputs();
    check_val("b2b_pulses", pulses, 2);
    check_val("b2b_spacing", pulse_at[1] - pulse_at[0], 8);
    check_val("b2b_err", bus_if.err_o, 0);

    // Throttled burst: fire / rready low / rvalid low, garbage on stalls
    push(26'h0000321, 3'd0);
    pulses = 0;
    nb = 0;
    for (int j = 0; j < 60 && nb < 8; j++) begin
      case (j % 3)
        0: begin
          bus_if.mem_rvalid_i = 1'b1; bus_if.mem_rready_i = 1'b1;
          bus_if.mem_rdata_i  = BASE1 + 64'(nb); bus_if.mem_rlast_i = (nb == 7);
          nb++;
        end
        1: begin
          bus_if.mem_rvalid_i = 1'b1; bus_if.mem_rready_i = 1'b0;
          bus_if.mem_rdata_i  = 64'hDEAD_BEEF_DEAD_BEEF; bus_if.mem_rlast_i = 1'b1;
        end
        default: begin
          bus_if.mem_rvalid_i = 1'b0; bus_if.mem_rready_i = 1'b1;
          bus_if.mem_rdata_i  = 64'hBAD0_BAD0_BAD0_BAD0; bus_if.mem_rlast_i = 1'b1;
        end
      endcase
      tick();
      if (bus_if.fill_wren_o) pulses++;
    end
    idle_inputs();
    for (int j = 0; j < 4; j++) begin
      tick();
      if (bus_if.fill_wren_o) pulses++;
    end
    check_val("thr_pulses", pulses, 1);
    check_val("thr_addr", bus_if.fill_addr_o, 26'h0000321);
    check_val("thr_line", bus_if.fill_wdata_o, exp_line(3'd0, BASE1));
    check_val("thr_err", bus_if.err_o, 0);

    // Reset mid-burst
    push(26'h1234567, 3'd4);
    push(26'h1234568, 3'd1);
    for (int k = 0; k < 4; k++) beat(BASEE + 64'(k), 1'b0);
    rst = 1'b1;
    #1;
    check_val("mr_wren",  bus_if.fill_wren_o, 0);
    check_val("mr_addr",  bus_if.fill_addr_o, 0);
    check_val("mr_wdata", bus_if.fill_wdata_o, 0);
    check_val("mr_busy",  bus_if.busy_o, 0);
    check_val("mr_empty", bus_if.miss_fifo_empty_o, 1);
    check_val("mr_afull", bus_if.miss_fifo_afull_o, 0);
    tick();
    rst = 1'b0;
    push(26'h0000777, 3'd2);
    burst(BASEG);
    check_val("mr_after_wren", bus_if.fill_wren_o, 1);
    check_val("mr_after_addr", bus_if.fill_addr_o, 26'h0000777);
    check_val("mr_after_line", bus_if.fill_wdata_o, exp_line(3'd2, BASEG));
    check_val("mr_after_err",  bus_if.err_o, 0);

    // Beat with FIFO empty
    do_reset();
    beat(64'h5555_5555_5555_5555, 1'b0);
    check_val("emp_err",  bus_if.err_o, 1);
    check_val("emp_busy", bus_if.busy_o, 0);
    tick();
    check_val("emp_wren", bus_if.fill_wren_o, 0);

    // Early rlast on beat 3, next burst still correct
    do_reset();
    push(26'h0000D0D, 3'd1);
    push(26'h0000E0E, 3'd6);
    for (int k = 0; k < 4; k++) beat(BASEA + 64'(k), k == 3);
    check_val("el_err",   bus_if.err_o, 1);
    check_val("el_busy",  bus_if.busy_o, 0);
    check_val("el_wren",  bus_if.fill_wren_o, 0);
    check_val("el_empty", bus_if.miss_fifo_empty_o, 0);
    burst(BASEE);
    check_val("el_next_wren", bus_if.fill_wren_o, 1);
    check_val("el_next_addr", bus_if.fill_addr_o, 26'h0000E0E);
    check_val("el_next_line", bus_if.fill_wdata_o, exp_line(3'd6, BASEE));

    // Fifth push into a full FIFO
    do_reset();
    push(26'h0000001, 3'd3);
    push(26'h0000002, 3'd0);
    push(26'h0000003, 3'd0);
    push(26'h0000004, 3'd0);
    check_val("full_err_before", bus_if.err_o, 0);
    check_val("full_afull", bus_if.miss_fifo_afull_o, 1);
    push(26'h0000005, 3'd0);
    check_val("full_err_after", bus_if.err_o, 1);
    burst(BASEB);
    check_val("full_head_addr", bus_if.fill_addr_o, 26'h0000001);
    check_val("full_head_line", bus_if.fill_wdata_o, exp_line(3'd3, BASEB));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
